// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream, instruction RAM write port and load status bundle
interface prog_loader_if #(
   parameter int AW = 8
);
   logic          start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_hold;
   logic          done;
   logic          err;
   logic [15:0]   words;

   // loader side
   modport master (
      input  start, in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err, words
   );

   // stream source / RAM / core side
   modport slave (
      output start, in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err, words
   );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time instruction RAM loader from a little-endian byte stream
module prog_loader #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   prog_loader_if.master bus
);
   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERR
   } state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t        state_q, state_d;
   logic [7:0]    cnt_lo_q, cnt_lo_d;
   logic [15:0]   count_q, count_d;
   logic [1:0]    idx_q, idx_d;
   logic [23:0]   buf_q, buf_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          core_hold_q, core_hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [15:0]   words_q, words_d;

   logic          in_ready;
   logic          accept;
   logic [15:0]   hdr_n;

   // ready is a pure decode of the state register so it never depends on in_valid
   always_comb begin
      in_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
      accept   = in_ready && bus.in_valid;
      hdr_n    = {bus.in_data, cnt_lo_q};
   end

   // next-state, byte assembly and write-pulse generation
   always_comb begin
      state_d     = state_q;
      cnt_lo_d    = cnt_lo_q;
      count_d     = count_q;
      idx_d       = idx_q;
      buf_d       = buf_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      core_hold_d = core_hold_q;
      done_d      = done_q;
      err_d       = err_q;
      words_d     = words_q;

      case (state_q)
         LEN_LO: begin
            if (accept) begin
               cnt_lo_d = bus.in_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               count_d = hdr_n;
               idx_d   = 2'd0;
               if (hdr_n == 16'd0) begin
                  state_d = DONE;
               end else if ({1'b0, hdr_n} > DEPTH_W) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               case (idx_q)
                  2'd0: buf_d[7:0]   = bus.in_data;
                  2'd1: buf_d[15:8]  = bus.in_data;
                  2'd2: buf_d[23:16] = bus.in_data;
                  default: begin
                     // the write address is the number of words already written
                     mem_wdata_d = {bus.in_data, buf_q};
                     mem_addr_d  = words_q[AW-1:0];
                     mem_we_d    = 1'b1;
                     words_d     = words_q + 16'd1;
                     if ((words_q + 16'd1) == count_q) begin
                        state_d = DONE;
                     end
                  end
               endcase
               idx_d = idx_q + 2'd1;
            end
         end
         DONE: begin
            // release lags DONE entry by one cycle so the last write lands first
            done_d      = 1'b1;
            core_hold_d = 1'b0;
            if (bus.start) begin
               state_d     = LEN_LO;
               done_d      = 1'b0;
               core_hold_d = 1'b1;
               words_d     = 16'd0;
               mem_addr_d  = '0;
               idx_d       = 2'd0;
            end
         end
         ERR: begin
            if (bus.start) begin
               state_d     = LEN_LO;
               err_d       = 1'b0;
               core_hold_d = 1'b1;
               words_d     = 16'd0;
               mem_addr_d  = '0;
               idx_d       = 2'd0;
            end
         end
         default: begin
            state_d = LEN_LO;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LEN_LO;
         cnt_lo_q    <= 8'd0;
         count_q     <= 16'd0;
         idx_q       <= 2'd0;
         buf_q       <= 24'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         core_hold_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         words_q     <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_lo_q    <= cnt_lo_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         buf_q       <= buf_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_hold_q <= core_hold_d;
         done_q      <= done_d;
         err_q       <= err_d;
         words_q     <= words_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.core_hold = core_hold_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.words     = words_q;
endmodule
